// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the fetch sequencer.
// Optional feature macro (used by fetch_sequencer): FETCH_INSTCOUNT_EN.
package fetch_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int DEF_A          = 10;  // PC / ROM address width
  localparam int DEF_OFS_W      = 8;   // signed branch offset width
  localparam int DEF_CNT_W      = 16;  // retired-instruction counter width
  localparam int DEF_START_ADDR = 0;   // PC loaded on every accepted Start

endpackage : fetch_pkg

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection for one RUN cycle.
// Priority: halt > jump > branch > sequential. A sequential step from the
// last address does not wrap; it holds the PC and requests a faulted stop.
module fetch_next_pc #(
  parameter int A     = 10,
  parameter int OFS_W = 8
) (
  input  logic [A-1:0]     pc,
  input  logic             halt,
  input  logic             jump_en,
  input  logic [A-1:0]     jump_target,
  input  logic             branch_taken,
  input  logic [OFS_W-1:0] branch_offset,
  output logic [A-1:0]     next_pc,
  output logic             stop,
  output logic             fault
);

  logic [A-1:0] ofs_ext;

  // Sign-extend the relative offset to PC width; the add then wraps mod 2**A.
  assign ofs_ext = {{(A - OFS_W){branch_offset[OFS_W-1]}}, branch_offset};

  // Pick the next PC and flag halt / fall-off-the-end conditions.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
    next_pc = pc;
    stop    = 1'b0;
    fault   = 1'b0;
    if (halt) begin
      stop = 1'b1;
    end else if (jump_en) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc + ofs_ext;
    end else if (pc == '1) begin
      stop  = 1'b1;
      fault = 1'b1;
    end else begin
      next_pc = pc + A'(1);
    end
  end

endmodule : fetch_next_pc

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and fetch controller for the instruction ROM.
// Handles Start/Done handshake, RUN sequencing with stall/halt/jump/branch,
// and an optional saturating retired-instruction counter enabled by the
// FETCH_INSTCOUNT_EN macro (InstCount reads 0 when the macro is undefined).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int           A          = DEF_A,
  parameter int           OFS_W      = DEF_OFS_W,
  parameter logic [A-1:0] START_ADDR = A'(DEF_START_ADDR),
  parameter int           CNT_W      = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             JumpEn,
  input  logic [A-1:0]     JumpTarget,
  input  logic             BranchTaken,
  input  logic [OFS_W-1:0] BranchOffset,
  output logic [A-1:0]     InstAddress,
  output logic             Running,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] InstCount
);

  state_e       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic         fault_q, fault_d;

  logic [A-1:0] np_next_pc;
  logic         np_stop;
  logic         np_fault;

  fetch_next_pc #(
    .A     (A),
    .OFS_W (OFS_W)
  ) u_next_pc (
    .pc            (pc_q),
    .halt          (Halt),
    .jump_en       (JumpEn),
    .jump_target   (JumpTarget),
    .branch_taken  (BranchTaken),
    .branch_offset (BranchOffset),
    .next_pc       (np_next_pc),
    .stop          (np_stop),
    .fault         (np_fault)
  );

  // State, PC and fault flag registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: Start only in IDLE/HALT; Stall freezes a RUN cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          pc_d    = START_ADDR;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!Stall) begin
          pc_d = np_next_pc;
          if (np_stop) state_d = HALT;
          if (np_fault) fault_d = 1'b1;
        end
      end
      HALT: begin
        if (Start) begin
          pc_d    = START_ADDR;
          fault_d = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  assign InstAddress = pc_q;
  assign Running     = (state_q == RUN);
  assign Done        = (state_q == HALT);
  assign Fault       = fault_q;

`ifdef FETCH_INSTCOUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Retired-instruction counter: clears on accepted Start, counts every
  // non-stalled RUN cycle (halt and faulting fetch included), saturates.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (Start && (state_q != RUN)) begin
      cnt_q <= '0;
    end else if ((state_q == RUN) && !Stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign InstCount = cnt_q;
`else
  assign InstCount = '0;
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed, table-driven check of fetch_sequencer.
// Expected InstCount follows FETCH_INSTCOUNT_EN (0 when the macro is undefined).
module tb_fetch_sequencer;

  localparam int A     = 10;
  localparam int OFS_W = 8;
  localparam int CNT_W = 16;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic             Stall;
  logic             Halt;
  logic             JumpEn;
  logic [A-1:0]     JumpTarget;
  logic             BranchTaken;
  logic [OFS_W-1:0] BranchOffset;
  logic [A-1:0]     InstAddress;
  logic             Running;
  logic             Done;
  logic             Fault;
  logic [CNT_W-1:0] InstCount;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(
    .A          (A),
    .OFS_W      (OFS_W),
    .START_ADDR (10'd0),
    .CNT_W      (CNT_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Stall        (Stall),
    .Halt         (Halt),
    .JumpEn       (JumpEn),
    .JumpTarget   (JumpTarget),
    .BranchTaken  (BranchTaken),
    .BranchOffset (BranchOffset),
    .InstAddress  (InstAddress),
    .Running      (Running),
    .Done         (Done),
    .Fault        (Fault),
    .InstCount    (InstCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string            name;
    logic             start;
    logic             stall;
    logic             halt;
    logic             jump_en;
    logic [A-1:0]     jump_target;
    logic             branch_taken;
    logic [OFS_W-1:0] branch_offset;
    int               exp_pc;
    logic             exp_running;
    logic             exp_done;
    logic             exp_fault;
    int               exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic int cnt_exp(input int n);
`ifdef FETCH_INSTCOUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int pc, input logic run,
                            input logic done, input logic flt, input int cnt);
    check({tag, ".pc"},      32'(InstAddress), 32'(pc));
    check({tag, ".running"}, 32'(Running),     32'(run));
    check({tag, ".done"},    32'(Done),        32'(done));
    check({tag, ".fault"},   32'(Fault),       32'(flt));
    check({tag, ".count"},   32'(InstCount),   32'(cnt_exp(cnt)));
  endtask

  // Drive one cycle of inputs, take the edge, sample 1ns later.
  task automatic step(input logic st, input logic sl, input logic hl, input logic je,
                      input int jt, input logic bt, input logic [OFS_W-1:0] bo);
    Start        = st;
    Stall        = sl;
    Halt         = hl;
    JumpEn       = je;
    JumpTarget   = A'(jt);
    BranchTaken  = bt;
    BranchOffset = bo;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic add(input string n, input logic st, input logic sl, input logic hl,
                     input logic je, input int jt, input logic bt, input logic [OFS_W-1:0] bo,
                     input int pc, input logic run, input logic done, input logic flt,
                     input int cnt);
    vec_t v;
    v.name = n; v.start = st; v.stall = sl; v.halt = hl; v.jump_en = je;
    v.jump_target = A'(jt); v.branch_taken = bt; v.branch_offset = bo;
    v.exp_pc = pc; v.exp_running = run; v.exp_done = done; v.exp_fault = flt;
    v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0; Stall = 1'b0; Halt = 1'b0; JumpEn = 1'b0; JumpTarget = '0;
    BranchTaken = 1'b0; BranchOffset = '0;

    //   name          st sl hl je  jt  bt  bo      pc  run dn flt cnt
    add("start",       1, 0, 0, 0,   0, 0, 8'h00,   0,  1, 0, 0,  0);
    add("seq1",        0, 0, 0, 0,   0, 0, 8'h00,   1,  1, 0, 0,  1);
    add("seq2",        0, 0, 0, 0,   0, 0, 8'h00,   2,  1, 0, 0,  2);
    add("seq3",        0, 0, 0, 0,   0, 0, 8'h00,   3,  1, 0, 0,  3);
    add("seq4",        0, 0, 0, 0,   0, 0, 8'h00,   4,  1, 0, 0,  4);
    add("seq5",        0, 0, 0, 0,   0, 0, 8'h00,   5,  1, 0, 0,  5);
    add("start_run",   1, 0, 0, 0,   0, 0, 8'h00,   6,  1, 0, 0,  6);
    add("jump100",     0, 0, 0, 1, 100, 0, 8'h00, 100,  1, 0, 0,  7);
    add("branch_m4",   0, 0, 0, 0,   0, 1, 8'hFC,  96,  1, 0, 0,  8);
    add("jump10",      0, 0, 0, 1,  10, 0, 8'h00,  10,  1, 0, 0,  9);
    add("jump_wins",   0, 0, 0, 1,  50, 1, 8'h02,  50,  1, 0, 0, 10);
    add("stall1",      0, 1, 0, 0,   0, 0, 8'h00,  50,  1, 0, 0, 10);
    add("stall2_halt", 0, 1, 1, 0,   0, 0, 8'h00,  50,  1, 0, 0, 10);
    add("stall3_jump", 0, 1, 0, 1, 300, 1, 8'h05,  50,  1, 0, 0, 10);
    add("halt50",      0, 0, 1, 0,   0, 0, 8'h00,  50,  0, 1, 0, 11);
    add("halt_hold",   0, 0, 0, 1, 400, 0, 8'h00,  50,  0, 1, 0, 11);
    add("restart",     1, 0, 0, 0,   0, 0, 8'h00,   0,  1, 0, 0,  0);

    // Reset state, with Start held during reset to show it is ignored.
    Start = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    #2;
    Reset = 1'b1;
    Start = 1'b0;
    idle_step();
    check_outs("idle", 0, 0, 0, 0, 0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].jump_en,
           int'(vecs[i].jump_target), vecs[i].branch_taken, vecs[i].branch_offset);
      check_outs(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_running, vecs[i].exp_done,
                 vecs[i].exp_fault, vecs[i].exp_cnt);
    end

    // Halt at PC=7 after 7 sequential retires; halt itself is the 8th.
    for (int i = 0; i < 7; i++) idle_step();
    check_outs("pre_halt7", 7, 1, 0, 0, 7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, '0);
    check_outs("halt7", 7, 0, 1, 0, 8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);
    check_outs("restart7", 0, 1, 0, 0, 0);

    // Sequential fetch past the last address faults and halts.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1023, 1'b0, '0);
    check_outs("jump1023", 1023, 1, 0, 0, 1);
    idle_step();
    check_outs("fault", 1023, 0, 1, 1, 2);
    idle_step();
    check_outs("fault_hold", 1023, 0, 1, 1, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);
    check_outs("fault_clear", 0, 1, 0, 0, 0);

    // Relative branch wraps modulo 2**A without faulting.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1022, 1'b0, '0);
    check_outs("jump1022", 1022, 1, 0, 0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h05);
    check_outs("branch_wrap", 3, 1, 0, 0, 2);

    // Asynchronous reset mid-RUN takes effect without a clock edge.
    step(1'b0, 1'b0, 1'b0, 1'b1, 200, 1'b0, '0);
    check_outs("jump200", 200, 1, 0, 0, 3);
    #2;
    Reset = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0, 0);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check_outs("reset_start", 0, 0, 0, 0, 0);
    #2;
    Reset = 1'b1;
    Start = 1'b0;
    idle_step();
    check_outs("post_reset", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_sequencer
